// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, core-side instruction port and redirect.
// The master modport is the fetch unit; the slave modport is memory plus core.
interface fetch_unit_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [15:0]   fetch_count;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetcher: one outstanding memory read feeding a 2-entry {instr, pc} FIFO.
// Define FETCH_COUNT_EN to add the 16-bit delivered-instruction counter on fetch_count.
module fetch_unit #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StRun, StWait, StDrop} state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] addr_q;
    logic          req_q;
    logic [1:0]    count_q;
    logic [DW-1:0] instr0_q, instr1_q;
    logic [AW-1:0] pc0_q, pc1_q;

    logic pop;
    logic push;

    assign pop  = (count_q != 2'd0) && bus.instr_ready;
    assign push = (state_q == StWait) && bus.mem_ack && !bus.redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            req_q    <= 1'b0;
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            // A redirect flushes after any same-edge pop; the popped entry is still delivered.
            if (bus.redirect) begin
                count_q <= 2'd0;
                pc_q    <= bus.redirect_pc;
            end else begin
                if (push) begin
                    pc_q <= pc_q + 1'b1;
                end
                case ({push, pop})
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            instr0_q <= bus.mem_rdata;
                            pc0_q    <= addr_q;
                        end else begin
                            instr1_q <= bus.mem_rdata;
                            pc1_q    <= addr_q;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        instr0_q <= instr1_q;
                        pc0_q    <= pc1_q;
                        count_q  <= count_q - 2'd1;
                    end
                    2'b11: begin
                        if (count_q == 2'd1) begin
                            instr0_q <= bus.mem_rdata;
                            pc0_q    <= addr_q;
                        end else begin
                            instr0_q <= instr1_q;
                            pc0_q    <= pc1_q;
                            instr1_q <= bus.mem_rdata;
                            pc1_q    <= addr_q;
                        end
                    end
                    default: ;
                endcase
            end

            case (state_q)
                StRun: begin
                    // Issue only with guaranteed space, so a push never meets a full FIFO.
                    if ((count_q < 2'd2) && !bus.redirect) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= StRun;
                    end else if (bus.redirect) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr       = instr0_q;
    assign bus.instr_pc    = pc0_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 16'h0000;
        end else if (pop) begin
            fetch_count_q <= fetch_count_q + 16'h0001;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`else
    assign bus.fetch_count = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter AW, 16, instruction address width in words.
REQ-002 SHALL have parameter DW, 16, instruction word width.
REQ-003 SHALL have parameter RESET_PC, 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_req  output  1  instruction memory read request.
REQ-007 SHALL have port mem_addr  output  AW  word address of the pending request.
REQ-008 SHALL have port mem_ack  input  1  memory response strobe; mem_rdata valid this cycle.
REQ-009 SHALL have port mem_rdata  input  DW  instruction word returned by memory.
REQ-010 SHALL have port instr_valid  output  1  head of prefetch buffer valid toward the core.
REQ-011 SHALL have port instr  output  DW  instruction at buffer head.
REQ-012 SHALL have port instr_pc  output  AW  address of instr.
REQ-013 SHALL have port instr_ready  input  1  core accepts instr this cycle.
REQ-014 SHALL have port redirect  input  1  branch/jump taken; discard prefetched stream.
REQ-015 SHALL have port redirect_pc  input  AW  new fetch address, sampled when redirect=1.
REQ-016 SHALL have port fetch_count  output  16  delivered-instruction counter (see Configuration).

Function
REQ-017 SHALL hold a 2-entry FIFO of {instr, pc}; instr_valid = (count != 0); instr/instr_pc show the head entry.
REQ-018 SHALL transfer one entry to the core on any edge where instr_valid=1 and instr_ready=1.
REQ-019 SHALL implement FSM states RUN (no request outstanding), WAIT (request outstanding), DROP (outstanding request whose response is discarded).
REQ-020 RUN: if count < 2 and redirect=0, SHALL register mem_req=1, mem_addr=pc, go to WAIT; else stay in RUN with mem_req=0.
REQ-021 WAIT/DROP: mem_req and mem_addr SHALL stay stable until the mem_ack edge.
REQ-022 WAIT + mem_ack + no redirect: push {mem_rdata, mem_addr}, pc <= pc+1, mem_req <= 0, go to RUN.
REQ-023 DROP + mem_ack: discard mem_rdata, mem_req <= 0, go to RUN.
REQ-024 mem_req SHALL deassert for at least one cycle between consecutive requests; one outstanding request maximum.
REQ-025 pc SHALL increment modulo 2^AW (all-ones wraps to 0).
REQ-026 redirect SHALL, on the same edge, flush the FIFO (count <= 0), set pc <= redirect_pc, and move WAIT->DROP, or WAIT+mem_ack->RUN with data discarded; DROP and RUN keep their state.
REQ-027 redirect concurrent with a core transfer: the transfer completes (counted), then the flush applies; no entry survives.
REQ-028 A push and a pop on the same edge SHALL leave count unchanged; a push never occurs when count=2 (a request is only issued with space).

Reset
REQ-029 While reset=0: state=RUN, pc=RESET_PC, count=0, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, applied asynchronously.
REQ-030 Reset asserted mid-request SHALL abandon the request; a mem_ack arriving after reset release while in RUN SHALL be ignored.
REQ-031 First mem_req=1 with mem_addr=RESET_PC SHALL appear on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro FETCH_COUNT_EN defined: fetch_count increments by 1 per core transfer (REQ-018), wraps 0xFFFF->0, cleared only by reset.
REQ-033 Macro FETCH_COUNT_EN undefined: no counter register; fetch_count tied to 0.

Verification
REQ-034 Reset release, mem_ack 1 cycle after each req, instr_ready=1 -> mem_addr sequence 0,1,2,3; instr_pc 0,1,2,3 in order; instr matches memory.
REQ-035 instr_ready=0, memory always acks -> exactly 2 fetches (addr 0,1), mem_req then stays 0, instr_valid=1 holding pc 0.
REQ-036 redirect to 0x0040 while WAIT on addr 5 -> ack for 5 discarded, next mem_addr=0x0040, first instr_pc=0x0040.
REQ-037 redirect_pc=0xFFFF, instr_ready=1 -> delivered instr_pc 0xFFFF then 0x0000.
REQ-038 FETCH_COUNT_EN defined, 10 transfers then redirect -> fetch_count=10; undefined -> fetch_count=0 throughout.
REQ-039 reset pulled low while mem_req=1, stray mem_ack after release -> no push, instr_valid=0 until first legitimate ack for RESET_PC.
